ddr3_pattern_chk: RTL and testbench
===================================

Name: ddr3_pattern_chk

Overview:
Parametrised successor to the fixed 16-bit incrementing write/read/compare test generator for the DDR3 controller user FIFOs. Writes WORDS words per pass into the controller write FIFO, waits, reads them back and compares against a regenerated expected stream. Supports selectable patterns, multi-pass runs, FIFO backpressure, saturating error counting and first-failure capture. Sits on the user clock beside ddr3_controler; its status drives the LED display block.

Parameters:
DATA_W, 16, data width (multiple of 8, 8..64)
WORDS, 1024, words per pass (≥2)
NUM_PASSES, 0, passes per run; 0 = run forever
GAP_CYC, 256, idle cycles between write phase end and read phase start
RD_LAT, 1, cycles from rd_req to rd_data valid (1..4)
ERR_W, 16, error counter width
AUTO_START, 1, 1 = start automatically on first init_calib_complete

Ports:
sys_clk  in  1  user clock (50 MHz in current build)
sys_rst  in  1  asynchronous active-high reset
init_calib_complete  in  1  DDR3 calibration done
start  in  1  one-cycle pulse; begins a run from IDLE
pat_sel  in  2  0 incrementing, 1 walking-one, 2 PRBS31, 3 checkerboard
wr_full  in  1  controller write FIFO full
wr_en  out  1  write strobe
wr_data  out  DATA_W  write word
rd_empty  in  1  controller read FIFO empty
rd_req  out  1  read request
rd_data  in  DATA_W  read word, valid RD_LAT cycles after rd_req
busy  out  1  run in progress
done  out  1  high after NUM_PASSES passes, until next start
error  out  1  sticky: any compare mismatch or calibration loss
calib_lost  out  1  sticky: init_calib_complete dropped mid-run
err_cnt  out  ERR_W  mismatches, saturating at all-ones
first_err_idx  out  clog2(WORDS)  word index of first mismatch
first_err_exp  out  DATA_W  expected value at first mismatch
first_err_got  out  DATA_W  received value at first mismatch
pass_cnt  out  16  completed passes, wraps at 65535

Behaviour:
- Reset: all outputs 0, FSM IDLE, LFSR = 31'h7FFF_FFFF.
- States: IDLE, WAIT_CAL, WRITE, GAP, READ, DRAIN, NEXT.
- IDLE -> WAIT_CAL on start, or on AUTO_START with an unused first run. Entry clears err_cnt, error, calib_lost, first_err_*, pass_cnt and done. pat_sel is sampled here and held for the run.
- WAIT_CAL -> WRITE when init_calib_complete=1.
- WRITE: wr_en=1 only when wr_full=0. wr_data = pattern(idx, pass); idx increments per accepted word. After word WORDS-1 -> GAP.
- GAP: count GAP_CYC cycles -> READ.
- READ: rd_req=1 only when rd_empty=0. Issued count goes to WORDS, then -> DRAIN.
- Compare pipeline: a RD_LAT-deep valid/index shift register tags each returned word. Compare uses the expected value regenerated from the tagged index.
- DRAIN: wait until the valid pipeline is empty -> NEXT.
- NEXT: pass_cnt+1. If NUM_PASSES≠0 and pass_cnt+1==NUM_PASSES, set done and go to IDLE. Otherwise go to WRITE with idx reset.
- Patterns:
  - inc = idx + pass_cnt, zero-extended or truncated to DATA_W.
  - walking-one = 1<<((idx+pass_cnt) mod DATA_W).
  - checkerboard = 0x55.. on even idx, 0xAA.. on odd, inverted on odd passes.
  - PRBS31: x^31+x^28+1, advanced once per word, output replicated to DATA_W. The write and check generators each own an LFSR, both reseeded to the same pass-dependent seed (7FFF_FFFF xor pass_cnt, forced nonzero) at pass start.
- Mismatch:
  - error=1.
  - err_cnt+1, saturating.
  - first_err_* loaded only when err_cnt was 0.
- Calibration drop in WRITE/GAP/READ/DRAIN: set calib_lost and error, flush the compare pipeline (discard in-flight words), go to WAIT_CAL, restart the current pass from idx 0. pass_cnt is unchanged.
- start while busy: ignored. busy=1 in every state except IDLE.
- sys_rst mid-run: immediate return to the reset state. Partial FIFO contents are the controller's concern.

Decomposition:
- Package ddr3_test_pkg: pat_sel encodings, FSM state enum, PRBS31 tap constants, LFSR seed.
- One sub-module, ddr3_pat_gen: combinational pattern of (mode, idx, pass) plus a registered PRBS LFSR with load/step. Instantiated twice, once for write and once for check.

Test Plan:
1. AUTO_START=1, WORDS=16, NUM_PASSES=1, pat 0, loopback FIFO model, calib rises at cycle 100 -> 16 writes 0..15, 16 reads, done=1, err_cnt=0, pass_cnt=1.
2. Model corrupts word 5 (bit0 flipped) in pass 0, pat 0 -> err_cnt=1, first_err_idx=5, first_err_exp=0x0005, first_err_got=0x0004, error=1.
3. wr_full toggled every other cycle, rd_empty high for 10 cycles mid-read, RD_LAT=3 -> exactly WORDS writes and reads, no mismatch, no rd_req while rd_empty=1.
4. pat 2, NUM_PASSES=3, DATA_W=32 -> write stream equals reference PRBS31 per pass, seeds differ per pass, err_cnt=0, done after pass 3.
5. calib drops during READ at word 8 -> calib_lost=1, error=1, err_cnt=0, restart same pass after calib returns.
6. ERR_W=4, model inverts every word, WORDS=32 -> err_cnt saturates at 15, first_err_idx=0.

Source files
------------

// File: rtl/ddr3_test_pkg.sv
// Shared types and constants for the DDR3 write/read/compare pattern checker.
// Holds the pattern encodings, FSM states and PRBS31 generator constants.
package ddr3_test_pkg;

    typedef enum logic [1:0] {
        PAT_INC  = 2'd0,
        PAT_WALK = 2'd1,
        PAT_PRBS = 2'd2,
        PAT_CHK  = 2'd3
    } pat_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_CAL = 3'd1,
        ST_WRITE    = 3'd2,
        ST_GAP      = 3'd3,
        ST_READ     = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_NEXT     = 3'd6
    } state_t;

    // x^31 + x^28 + 1, Fibonacci form: feedback from bits 30 and 27
    localparam int          PRBS_TAP_A = 30;
    localparam int          PRBS_TAP_B = 27;
    localparam logic [30:0] LFSR_SEED  = 31'h7FFF_FFFF;

    // Pass-dependent seed; an all-zero LFSR would lock up, so fall back to the base seed
    function automatic logic [30:0] prbs_seed(input logic [15:0] pass);
        logic [30:0] s;
        s = LFSR_SEED ^ {15'd0, pass};
        return (s == 31'd0) ? LFSR_SEED : s;
    endfunction

endpackage

// File: rtl/ddr3_pat_gen.sv
// Pattern generator: combinational word from (mode, idx, pass) plus a PRBS31 LFSR
// that is reseeded with load and advanced one step per word with step.
module ddr3_pat_gen
    import ddr3_test_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  pat_t              mode,
    input  logic [IDX_W-1:0]  idx,
    input  logic [15:0]       pass,
    input  logic              load,
    input  logic [30:0]       seed,
    input  logic              step,
    output logic [DATA_W-1:0] pattern
);

    localparam logic [DATA_W-1:0] ONE    = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] CHK_55 = {(DATA_W/2){2'b01}};

    logic [30:0]       lfsr;
    logic [63:0]       sum;
    logic [DATA_W-1:0] prbs_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else if (load)
            lfsr <= seed;
        else if (step)
            lfsr <= {lfsr[29:0], lfsr[PRBS_TAP_A] ^ lfsr[PRBS_TAP_B]};
    end

    assign sum = 64'(idx) + 64'(pass);

    // The 31-bit state is repeated across the word so any DATA_W sees the full sequence
    always_comb begin
        prbs_word = '0;
        for (int b = 0; b < DATA_W; b++)
            prbs_word[b] = lfsr[b % 31];
    end

    always_comb begin
        pattern = '0;
        case (mode)
            PAT_INC:  pattern = sum[DATA_W-1:0];
            PAT_WALK: pattern = ONE << (sum % 64'(DATA_W));
            PAT_PRBS: pattern = prbs_word;
            PAT_CHK:  pattern = (idx[0] ^ pass[0]) ? ~CHK_55 : CHK_55;
            default:  pattern = '0;
        endcase
    end

endmodule

// File: rtl/ddr3_pattern_chk.sv
// Write/read/compare traffic generator for the DDR3 controller user FIFOs with
// selectable patterns, multi-pass runs, saturating error count and first-failure capture.
module ddr3_pattern_chk
    import ddr3_test_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int WORDS      = 1024,
    parameter int NUM_PASSES = 0,
    parameter int GAP_CYC    = 256,
    parameter int RD_LAT     = 1,
    parameter int ERR_W      = 16,
    parameter int AUTO_START = 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     init_calib_complete,
    input  logic                     start,
    input  logic [1:0]               pat_sel,
    input  logic                     wr_full,
    output logic                     wr_en,
    output logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_empty,
    output logic                     rd_req,
    input  logic [DATA_W-1:0]        rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     calib_lost,
    output logic [ERR_W-1:0]         err_cnt,
    output logic [$clog2(WORDS)-1:0] first_err_idx,
    output logic [DATA_W-1:0]        first_err_exp,
    output logic [DATA_W-1:0]        first_err_got,
    output logic [15:0]              pass_cnt,
    output logic [2:0]               dbg_state
);

    localparam int               IDX_W    = $clog2(WORDS);
    localparam int               GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t            state, state_nxt;
    pat_t              mode;
    logic [IDX_W-1:0]  idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic [RD_LAT-1:0] vld_pipe;
    logic [IDX_W-1:0]  tag_pipe [RD_LAT];
    logic              auto_used;
    logic              run_start, calib_drop, run_end;
    logic [15:0]       pass_nxt;
    logic              seed_load;
    logic [30:0]       seed;
    logic [DATA_W-1:0] wr_pat, exp_pat;
    logic              cmp_vld, cmp_step, mism;
    logic [IDX_W-1:0]  cmp_idx;

    assign pass_nxt  = pass_cnt + 16'd1;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;
    assign cmp_vld   = vld_pipe[RD_LAT-1];
    assign cmp_idx   = tag_pipe[RD_LAT-1];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // FIFO handshake: wr_en is only raised while wr_full=0 and rd_req only while
    // rd_empty=0; every cycle the strobe is high transfers exactly one word.
    always_comb begin
        state_nxt  = state;
        run_start  = 1'b0;
        calib_drop = 1'b0;
        run_end    = 1'b0;
        wr_en      = 1'b0;
        rd_req     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start || (AUTO_START != 0 && !auto_used && init_calib_complete)) begin
                    state_nxt = ST_WAIT_CAL;
                    run_start = 1'b1;
                end
            end
            ST_WAIT_CAL: if (init_calib_complete) state_nxt = ST_WRITE;
            ST_WRITE: begin
                wr_en = !wr_full;
                if (wr_en && idx == LAST_IDX) state_nxt = ST_GAP;
            end
            ST_GAP: if (gap_cnt == GAP_LAST) state_nxt = ST_READ;
            ST_READ: begin
                rd_req = !rd_empty;
                if (rd_req && idx == LAST_IDX) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (vld_pipe == '0) state_nxt = ST_NEXT;
            ST_NEXT: begin
                if (NUM_PASSES != 0 && 32'(pass_nxt) == NUM_PASSES) begin
                    state_nxt = ST_IDLE;
                    run_end   = 1'b1;
                end else begin
                    state_nxt = ST_WRITE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Losing calibration restarts the current pass once the controller is back
        if (!init_calib_complete && (state inside {ST_WRITE, ST_GAP, ST_READ, ST_DRAIN})) begin
            calib_drop = 1'b1;
            state_nxt  = ST_WAIT_CAL;
        end
    end

    // Both generators are reseeded at every pass start, using the pass about to run
    assign seed_load = (state == ST_WAIT_CAL) || (state == ST_NEXT);
    assign seed      = prbs_seed((state == ST_NEXT) ? pass_nxt : pass_cnt);
    assign cmp_step  = cmp_vld && !calib_drop;
    assign mism      = cmp_step && (rd_data != exp_pat);
    assign wr_data   = (state == ST_WRITE) ? wr_pat : '0;

    ddr3_pat_gen #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_wr_gen (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .mode    (mode),
        .idx     (idx),
        .pass    (pass_cnt),
        .load    (seed_load),
        .seed    (seed),
        .step    (wr_en),
        .pattern (wr_pat)
    );

    ddr3_pat_gen #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_chk_gen (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .mode    (mode),
        .idx     (cmp_idx),
        .pass    (pass_cnt),
        .load    (seed_load),
        .seed    (seed),
        .step    (cmp_step),
        .pattern (exp_pat)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode          <= PAT_INC;
            auto_used     <= 1'b0;
            idx           <= '0;
            gap_cnt       <= '0;
            vld_pipe      <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            calib_lost    <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
            pass_cnt      <= '0;
        end else begin
            if (run_start) begin
                mode          <= pat_t'(pat_sel);
                auto_used     <= 1'b1;
                done          <= 1'b0;
                error         <= 1'b0;
                calib_lost    <= 1'b0;
                err_cnt       <= '0;
                first_err_idx <= '0;
                first_err_exp <= '0;
                first_err_got <= '0;
                pass_cnt      <= '0;
            end

            // One index counter serves the write and then the read phase
            if (state != state_nxt)
                idx <= '0;
            else if (wr_en || rd_req)
                idx <= idx + 1'b1;

            if (state != ST_GAP) gap_cnt <= '0;
            else                 gap_cnt <= gap_cnt + 1'b1;

            // Tag each request with its index so returning data is checked in order
            if (calib_drop) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe[0] <= rd_req;
                tag_pipe[0] <= idx;
                for (int i = 1; i < RD_LAT; i++) begin
                    vld_pipe[i] <= vld_pipe[i-1];
                    tag_pipe[i] <= tag_pipe[i-1];
                end
            end

            if (mism) begin
                error <= 1'b1;
                if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
                if (err_cnt == '0) begin
                    first_err_idx <= cmp_idx;
                    first_err_exp <= exp_pat;
                    first_err_got <= rd_data;
                end
            end

            if (calib_drop) begin
                calib_lost <= 1'b1;
                error      <= 1'b1;
            end

            if (state == ST_NEXT) pass_cnt <= pass_nxt;
            if (run_end)          done     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr3_pattern_chk.sv
// Bench for ddr3_pattern_chk: loopback FIFO model with corruption and backpressure,
// table-driven runs plus hand sequences for auto start, calibration loss and reset.
module tb_ddr3_pattern_chk;
    import ddr3_test_pkg::*;

    localparam int DW     = 32;
    localparam int NW     = 32;
    localparam int NP     = 3;
    localparam int TOTAL  = NW * NP;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_calib_complete = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    pat_sel = 2'd0;
    logic          wr_full = 1'b0;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_empty = 1'b1;
    logic          rd_req;
    logic [DW-1:0] rd_data = '0;
    logic          busy, done, error, calib_lost;
    logic [3:0]    err_cnt;
    logic [4:0]    first_err_idx;
    logic [DW-1:0] first_err_exp, first_err_got;
    logic [15:0]   pass_cnt;
    logic [2:0]    dbg_state;

    ddr3_pattern_chk #(
        .DATA_W(DW), .WORDS(NW), .NUM_PASSES(NP), .GAP_CYC(8),
        .RD_LAT(3), .ERR_W(4), .AUTO_START(1)
    ) dut (
        .sys_clk             (clk),
        .sys_rst             (rst),
        .init_calib_complete (init_calib_complete),
        .start               (start),
        .pat_sel             (pat_sel),
        .wr_full             (wr_full),
        .wr_en               (wr_en),
        .wr_data             (wr_data),
        .rd_empty            (rd_empty),
        .rd_req              (rd_req),
        .rd_data             (rd_data),
        .busy                (busy),
        .done                (done),
        .error               (error),
        .calib_lost          (calib_lost),
        .err_cnt             (err_cnt),
        .first_err_idx       (first_err_idx),
        .first_err_exp       (first_err_exp),
        .first_err_got       (first_err_got),
        .pass_cnt            (pass_cnt),
        .dbg_state           (dbg_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- FIFO model + write scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] fifo_q[$];
    int            corrupt = 0;      // 0 none, 1 flip bit0 of one word, 2 invert all
    int            corrupt_at = -1;
    int            hold_at = -1;
    bit            bp = 1'b0;
    bit            sb_en = 1'b0;
    int            wcnt = 0, rdcnt = 0, viol = 0, hold = 0;
    logic [DW-1:0] w, pop_v;
    logic [DW-1:0] nxt_d0 = '0, d0 = '0, d1 = '0;
    logic          nxt_empty = 1'b1;

    // Sample the strobes mid-cycle; the transfer they describe happens at the next rising edge
    always @(negedge clk) begin
        if (!rst) begin
            if (hold != 0) hold--;
            if (wr_en) begin
                if (wr_full) viol++;
                if (sb_en) begin
                    if (exp_q.size() == 0) check("wr_extra", 1, 0);
                    else check("wr_data", wr_data, exp_q.pop_front());
                end
                w = wr_data;
                if (corrupt == 1 && wcnt == corrupt_at) w[0] = ~w[0];
                if (corrupt == 2) w = ~w;
                fifo_q.push_back(w);
                wcnt++;
            end
            pop_v = '0;
            if (rd_req) begin
                if (rd_empty || fifo_q.size() == 0) viol++;
                else pop_v = fifo_q.pop_front();
                if (bp && rdcnt == hold_at) hold = 10;
                rdcnt++;
            end
            nxt_d0    = pop_v;
            nxt_empty = (fifo_q.size() == 0) || (hold != 0);
        end
    end

    always @(posedge clk) begin
        if (rst || !init_calib_complete) begin
            fifo_q.delete();
            hold     = 0;
            rd_empty <= 1'b1;
            wr_full  <= 1'b0;
        end else begin
            rd_empty <= nxt_empty;
            wr_full  <= bp ? ~wr_full : 1'b0;
        end
        d0      <= nxt_d0;
        d1      <= d0;
        rd_data <= d1;
    end

    // ---------------- reference patterns ----------------
    task automatic fill_exp(input logic [1:0] pat);
        logic [30:0] s;
        exp_q.delete();
        for (int p = 0; p < NP; p++) begin
            s = 31'h7FFF_FFFF ^ 31'(p);
            for (int i = 0; i < NW; i++) begin
                case (pat)
                    2'd0: exp_q.push_back(32'(i + p));
                    2'd1: exp_q.push_back(32'd1 << ((i + p) % DW));
                    2'd2: exp_q.push_back({s[0], s});
                    default: exp_q.push_back(((i + p) % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555);
                endcase
                s = {s[29:0], s[30] ^ s[27]};
            end
        end
    endtask

    // ---------------- run table ----------------
    typedef struct {
        logic [1:0]    pat;
        int            corrupt;
        bit            bp;
        logic [3:0]    e_cnt;
        bit            e_error;
        logic [4:0]    e_idx;
        logic [DW-1:0] e_exp;
        logic [DW-1:0] e_got;
    } vec_t;

    vec_t vecs[5];
    vec_t auto_v;
    int   w0, r0, v0;

    task automatic arm(input vec_t v, input bit use_sb);
        pat_sel    = v.pat;
        corrupt    = v.corrupt;
        bp         = v.bp;
        corrupt_at = wcnt + 5;
        hold_at    = rdcnt + 8;
        w0 = wcnt; r0 = rdcnt; v0 = viol;
        fill_exp(v.pat);
        sb_en = use_sb;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && !done; i++) @(negedge clk);
        check("done", done, 1);
    endtask

    task automatic finish_run(input vec_t v, input bit full_chk);
        wait_done(6000);
        @(negedge clk);
        check("busy_end", busy, 0);
        check("pass_cnt", pass_cnt, NP);
        check("err_cnt", err_cnt, v.e_cnt);
        check("error", error, v.e_error);
        check("first_err_idx", first_err_idx, v.e_idx);
        check("first_err_exp", first_err_exp, v.e_exp);
        check("first_err_got", first_err_got, v.e_got);
        check("handshake_viol", viol - v0, 0);
        if (full_chk) begin
            check("calib_lost", calib_lost, 0);
            check("wr_count", wcnt - w0, TOTAL);
            check("rd_count", rdcnt - r0, TOTAL);
            check("exp_q_left", exp_q.size(), 0);
        end
        sb_en = 1'b0;
        bp    = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'd0, 1, 1'b0, 4'd1,  1'b1, 5'd5, 32'h0000_0005, 32'h0000_0004};
        vecs[1] = '{2'd1, 0, 1'b1, 4'd0,  1'b0, 5'd0, 32'h0,         32'h0};
        vecs[2] = '{2'd2, 0, 1'b0, 4'd0,  1'b0, 5'd0, 32'h0,         32'h0};
        vecs[3] = '{2'd3, 2, 1'b0, 4'd15, 1'b1, 5'd0, 32'h5555_5555, 32'hAAAA_AAAA};
        vecs[4] = '{2'd2, 2, 1'b1, 4'd15, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0000_0000};
        auto_v  = '{2'd0, 0, 1'b0, 4'd0,  1'b0, 5'd0, 32'h0,         32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_req", rd_req, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_pass_cnt", pass_cnt, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;

        // Auto start waits for calibration, which arrives around cycle 100
        arm(auto_v, 1'b1);
        repeat (97) @(negedge clk);
        check("idle_before_calib", busy, 0);
        init_calib_complete = 1'b1;
        @(negedge clk);
        check("auto_started", busy, 1);

        // A start pulse mid-run must not restart the run
        for (int i = 0; i < 3000 && pass_cnt != 16'd1; i++) @(negedge clk);
        check("reach_pass1", pass_cnt, 1);
        pulse_start();
        @(negedge clk);
        check("start_ignored", pass_cnt, 1);
        finish_run(auto_v, 1'b1);

        // Table of full runs
        for (int k = 0; k < 5; k++) begin
            arm(vecs[k], 1'b1);
            pulse_start();
            check("done_cleared", done, 0);
            check("busy_start", busy, 1);
            finish_run(vecs[k], 1'b1);
        end

        // Calibration drop during the read phase of pass 0
        arm(auto_v, 1'b0);
        pulse_start();
        for (int i = 0; i < 3000 && (rdcnt - r0) < 8; i++) @(posedge clk);
        check("reach_read8", ((rdcnt - r0) >= 8), 1);
        @(negedge clk) init_calib_complete = 1'b0;
        repeat (2) @(negedge clk);
        check("drop_state", dbg_state, ST_WAIT_CAL);
        check("drop_calib_lost", calib_lost, 1);
        check("drop_error", error, 1);
        check("drop_pass_cnt", pass_cnt, 0);
        check("drop_busy", busy, 1);
        repeat (20) @(negedge clk);
        init_calib_complete = 1'b1;
        finish_run('{2'd0, 0, 1'b0, 4'd0, 1'b1, 5'd0, 32'h0, 32'h0}, 1'b0);
        check("drop_calib_sticky", calib_lost, 1);

        // Reset in the middle of an erroring run
        arm('{2'd0, 2, 1'b0, 4'd0, 1'b0, 5'd0, 32'h0, 32'h0}, 1'b0);
        pulse_start();
        for (int i = 0; i < 3000 && pass_cnt != 16'd1; i++) @(negedge clk);
        check("pre_rst_err_cnt", err_cnt, 15);
        rst = 1'b1;
        #1;
        check("mid_rst_state", dbg_state, ST_IDLE);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err_cnt", err_cnt, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_pass_cnt", pass_cnt, 0);
        check("mid_rst_first_got", first_err_got, 0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
